shift_seq_ctrl: RTL and testbench

- Controller that sequences one external parallel-load shift register.
- Accepts a parallel word over a valid/ready handshake and issues one load strobe, then exactly WIDTH shift strobes, then a one-cycle done pulse.
- An internal bit counter tracks shift progress.
- Sits between a word producer and the serialiser datapath; owns all of the shift register's control timing.

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_bit_counter.sv | 43 ++++
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding and default sizes for the shift sequencer
package shift_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - bit counter with terminal count that wraps to zero on the last shift
module shift_bit_counter #(
    parameter int              CNT_W = 4,
    parameter logic [CNT_W-1:0] LAST = '1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    output logic [CNT_W-1:0] Cnt,
    output logic             Tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign Tc  = (cnt_q == LAST);
    assign Cnt = cnt_q;

    // next count: clear wins, otherwise step and wrap at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (Clear) begin
            cnt_d = '0;
        end else if (Enable) begin
            if (Tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // count register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load/shift/done sequencer for a parallel-load shift register (optional SHIFT_SEQ_CTRL_PAUSE_EN)
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Data,
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    input  logic             Pause,
`endif
    output logic [WIDTH-1:0] Sr_Data,
    output logic             Sr_Load,
    output logic             Sr_Shift,
    output logic [CNT_W-1:0] Bit_Cnt,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sr_data_q;
    logic [WIDTH-1:0] sr_data_d;
    logic             pause_w;
    logic             accept_w;
    logic             cnt_tc;
    logic             cnt_clear;
    logic             cnt_en;

`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    assign pause_w = Pause;
`else
    assign pause_w = 1'b0;
`endif

    // ready is held low through reset so nothing is accepted on the reset edge
    assign In_Ready  = (state_q == IDLE) && !Reset;
    assign accept_w  = In_Valid && In_Ready;

    // counter runs only in SHIFT and is held at zero elsewhere
    assign cnt_clear = (state_q != SHIFT);
    assign cnt_en    = (state_q == SHIFT) && !pause_w;

    shift_bit_counter #(
        .CNT_W (CNT_W),
        .LAST  (LAST)
    ) u_bit_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (cnt_clear),
        .Enable (cnt_en),
        .Cnt    (Bit_Cnt),
        .Tc     (cnt_tc)
    );

    // next state, word capture and strobe decodes
    always_comb begin
        state_d   = state_q;
        sr_data_d = sr_data_q;
        Sr_Load   = 1'b0;
        Sr_Shift  = 1'b0;
        Done      = 1'b0;
        Busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    sr_data_d = In_Data;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                Sr_Load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                Sr_Shift = !pause_w;
                if (!pause_w && cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and captured-word registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            sr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_data_q <= sr_data_d;
        end
    end

    assign Sr_Data = sr_data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [WIDTH-1:0] In_Data = '0;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    logic             Pause = 1'b0;
`endif
    logic [WIDTH-1:0] Sr_Data;
    logic             Sr_Load;
    logic             Sr_Shift;
    logic [CNT_W-1:0] Bit_Cnt;
    logic             Busy;
    logic             Done;

    int n_cmp = 0;
    int n_err = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Data  (In_Data),
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
        .Pause    (Pause),
`endif
        .Sr_Data  (Sr_Data),
        .Sr_Load  (Sr_Load),
        .Sr_Shift (Sr_Shift),
        .Bit_Cnt  (Bit_Cnt),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // present a word in IDLE and let the next edge take it
    task automatic accept_word(input logic [WIDTH-1:0] d);
        In_Valid = 1'b1;
        In_Data  = d;
        #1;
        n_cmp++;
        if (In_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready got=%b want=1", In_Ready);
        end
        tick();
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({In_Ready, Busy, Sr_Load, Sr_Shift, Done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000", {In_Ready, Busy, Sr_Load, Sr_Shift, Done});
        end
        n_cmp++;
        if (Bit_Cnt !== 4'd0 || Sr_Data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_regs got cnt=%0d data=%h want cnt=0 data=00", Bit_Cnt, Sr_Data);
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({In_Ready, Busy, Sr_Load, Sr_Shift, Done} !== 5'b10000 || Bit_Cnt !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset got=%b cnt=%0d want=10000 cnt=0",
                     {In_Ready, Busy, Sr_Load, Sr_Shift, Done}, Bit_Cnt);
        end
    endtask

    task automatic test_single();
        accept_word(8'hA5);
        n_cmp++;
        if (Sr_Load !== 1'b1 || Sr_Shift !== 1'b0 || Done !== 1'b0 || Sr_Data !== 8'hA5 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_load got load=%b shift=%b done=%b data=%h busy=%b want 1 0 0 a5 1",
                     Sr_Load, Sr_Shift, Done, Sr_Data, Busy);
        end
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            n_cmp++;
            if (Sr_Shift !== 1'b1 || Sr_Load !== 1'b0 || Done !== 1'b0 || Bit_Cnt !== 4'(i) || In_Ready !== 1'b0) begin
                n_err++;
                $display("FAIL single_shift%0d got shift=%b load=%b done=%b cnt=%0d rdy=%b want 1 0 0 %0d 0",
                         i, Sr_Shift, Sr_Load, Done, Bit_Cnt, In_Ready, i);
            end
        end
        tick();
        n_cmp++;
        if (Done !== 1'b1 || Sr_Shift !== 1'b0 || Bit_Cnt !== 4'd0 || In_Ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_done got done=%b shift=%b cnt=%0d rdy=%b want 1 0 0 0",
                     Done, Sr_Shift, Bit_Cnt, In_Ready);
        end
        tick();
        n_cmp++;
        if (In_Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Sr_Data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_idle got rdy=%b busy=%b done=%b data=%h want 1 0 0 a5",
                     In_Ready, Busy, Done, Sr_Data);
        end
    endtask

    task automatic test_back_to_back();
        int first_t;
        int second_t;
        int done_t;
        first_t  = -1;
        second_t = -1;
        done_t   = -1;
        In_Valid = 1'b1;
        In_Data  = 8'h3C;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (Sr_Load === 1'b1) begin
                if (first_t < 0) begin
                    first_t = t;
                    n_cmp++;
                    if (Sr_Data !== 8'h3C) begin
                        n_err++;
                        $display("FAIL b2b_word1 got=%h want=3c", Sr_Data);
                    end
                    In_Data = 8'hC3;
                end else if (second_t < 0) begin
                    second_t = t;
                    n_cmp++;
                    if (Sr_Data !== 8'hC3) begin
                        n_err++;
                        $display("FAIL b2b_word2 got=%h want=c3", Sr_Data);
                    end
                    In_Valid = 1'b0;
                end
            end
            if (Done === 1'b1 && done_t < 0) begin
                done_t = t;
                n_cmp++;
                if (In_Ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_ready_in_done got=%b want=0", In_Ready);
                end
            end
        end
        In_Valid = 1'b0;
        n_cmp++;
        if (second_t - first_t !== 11 || first_t < 0) begin
            n_err++;
            $display("FAIL b2b_spacing got first=%0d second=%0d want spacing 11", first_t, second_t);
        end
        n_cmp++;
        if (done_t !== first_t + 9) begin
            n_err++;
            $display("FAIL b2b_done_pos got=%0d want=%0d", done_t, first_t + 9);
        end
    endtask

    task automatic test_data_stability();
        int bad;
        bad = 0;
        accept_word(8'h0F);
        tick();
        In_Data = 8'hFF;
        for (int t = 0; t < 12; t++) begin
            #1;
            if (Sr_Data !== 8'h0F) bad++;
            tick();
        end
        n_cmp++;
        if (bad !== 0 || Sr_Data !== 8'h0F) begin
            n_err++;
            $display("FAIL stable_data got=%h bad_cycles=%0d want=0f", Sr_Data, bad);
        end
        accept_word(8'h81);
        n_cmp++;
        if (Sr_Data !== 8'h81 || Sr_Load !== 1'b1) begin
            n_err++;
            $display("FAIL stable_next got data=%h load=%b want 81 1", Sr_Data, Sr_Load);
        end
        for (int t = 0; t < 10; t++) tick();
    endtask

    task automatic test_reset_mid();
        int strobes;
        int guard;
        strobes = 0;
        guard   = 0;
        accept_word(8'h5A);
        tick();
        while (Bit_Cnt !== 4'd4 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (Bit_Cnt !== 4'd4 || Sr_Shift !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reach4 got cnt=%0d shift=%b want 4 1", Bit_Cnt, Sr_Shift);
        end
        Reset = 1'b1;
        tick();
        n_cmp++;
        if (Busy !== 1'b0 || Bit_Cnt !== 4'd0 || Sr_Data !== 8'h00 || Done !== 1'b0 || In_Ready !== 1'b0 || Sr_Shift !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got busy=%b cnt=%0d data=%h done=%b rdy=%b shift=%b want 0 0 00 0 0 0",
                     Busy, Bit_Cnt, Sr_Data, Done, In_Ready, Sr_Shift);
        end
        Reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (Done === 1'b1 || Sr_Shift === 1'b1 || Sr_Load === 1'b1) strobes++;
        end
        n_cmp++;
        if (strobes !== 0 || In_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_after got strobe_cycles=%0d rdy=%b want 0 1", strobes, In_Ready);
        end
    endtask

`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    task automatic test_pause();
        int shifts;
        int done_t;
        int pause_bad;
        shifts    = 0;
        done_t    = -1;
        pause_bad = 0;
        accept_word(8'h96);
        for (int t = 2; t <= 16; t++) begin
            tick();
            Pause = (t >= 4 && t <= 6);
            #1;
            if (Pause && (Sr_Shift !== 1'b0 || Bit_Cnt !== 4'd2)) pause_bad++;
            if (Sr_Shift === 1'b1) shifts++;
            if (Done === 1'b1 && done_t < 0) done_t = t;
        end
        Pause = 1'b0;
        n_cmp++;
        if (pause_bad !== 0) begin
            n_err++;
            $display("FAIL pause_hold got bad_cycles=%0d want=0", pause_bad);
        end
        n_cmp++;
        if (shifts !== 8) begin
            n_err++;
            $display("FAIL pause_shifts got=%0d want=8", shifts);
        end
        n_cmp++;
        if (done_t !== 13) begin
            n_err++;
            $display("FAIL pause_done got=%0d want=13", done_t);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_data_stability();
        test_reset_mid();
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=stalled want=finished");
        $fatal(1, "timeout");
    end

endmodule
